// File: rtl/snowflake_uart_pkg.sv
// Shared types and constants for the snowflake UART transmitter.
// Register offsets are word offsets decoded from sys_addr[7:2].
package snowflake_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [5:0] REG_TXDATA = 6'h00;
  localparam logic [5:0] REG_STATUS = 6'h01;
  localparam logic [5:0] REG_CLKDIV = 6'h02;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_COUNT = 8;

endpackage

// File: rtl/snowflake_uart_tx_if.sv
// Snowflake system bus slave port as seen by the UART peripheral.
// Handshake: sys_en is a one-cycle strobe and the slave is always ready; a read
// (sys_wr_en=0) updates sys_rd_data on that edge and it holds until the next read.
interface snowflake_uart_tx_if;
  logic [31:0] sys_addr;
  logic [31:0] sys_wr_data;
  logic [31:0] sys_rd_data;
  logic        sys_en;
  logic        sys_wr_en;

  modport master (
    output sys_addr, sys_wr_data, sys_en, sys_wr_en,
    input  sys_rd_data
  );

  modport slave (
    input  sys_addr, sys_wr_data, sys_en, sys_wr_en,
    output sys_rd_data
  );
endinterface

// File: rtl/snowflake_fifo.sv
// Synchronous FIFO with first-word-fall-through read data.
// Push on full and pop on empty are ignored.
module snowflake_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/snowflake_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO and baud FSM.
// tx is registered from the FSM state, so the line lags the state by one cycle.
module snowflake_uart_tx
  import snowflake_uart_pkg::*;
#(
  parameter int          DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd207
) (
  input  logic                      clk,
  input  logic                      rst,
  snowflake_uart_tx_if.slave        sys,
  output logic                      tx,
  output logic                      irq_empty,
  output tx_state_e                 state_dbg
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [5:0]    offset;
  logic          wr, rd, push, pop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic [15:0]   clkdiv;
  logic          overflow;
  logic [31:0]   rd_data, rd_mux, status;
  tx_state_e     state, state_next;
  logic [15:0]   baud, baud_next;
  logic [7:0]    shift, shift_next;
  logic [2:0]    idx, idx_next;
  logic          tx_next;
  logic          unused_bits;

  assign offset          = sys.sys_addr[7:2];
  assign wr              = sys.sys_en & sys.sys_wr_en;
  assign rd              = sys.sys_en & ~sys.sys_wr_en;
  assign push            = wr && (offset == REG_TXDATA);
  assign sys.sys_rd_data = rd_data;
  assign state_dbg       = state;
  assign unused_bits     = ^{sys.sys_addr[31:8], sys.sys_addr[1:0], sys.sys_wr_data[31:16]};

  snowflake_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (sys.sys_wr_data[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status           = '0;
    status[ST_BUSY]  = (state != IDLE) | ~fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_OVF]   = overflow;
    status[ST_COUNT +: 7] = 7'(fifo_count);
    rd_mux = '0;
    case (offset)
      REG_STATUS: rd_mux = status;
      REG_CLKDIV: rd_mux = {16'h0000, clkdiv};
      default:    rd_mux = '0;
    endcase
  end

  // The full check uses the pre-pop count, so a push on full is lost even if the FSM pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clkdiv   <= DEFAULT_DIV;
      overflow <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (wr && (offset == REG_CLKDIV)) clkdiv <= sys.sys_wr_data[15:0];
      if (push && fifo_full) overflow <= 1'b1;
      else if (wr && (offset == REG_STATUS) && sys.sys_wr_data[ST_OVF]) overflow <= 1'b0;
      if (rd) rd_data <= rd_mux;
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud;
    shift_next = shift;
    idx_next   = idx;
    pop        = 1'b0;
    tx_next    = 1'b1;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_rdata;
          baud_next  = clkdiv;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (baud == '0) begin
          baud_next  = clkdiv;
          idx_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud - 16'd1;
        end
      end
      DATA: begin
        tx_next = shift[0];
        if (baud == '0) begin
          baud_next  = clkdiv;
          shift_next = {1'b0, shift[7:1]};
          idx_next   = idx + 3'd1;
          if (idx == 3'd7) state_next = STOP;
        end else begin
          baud_next = baud - 16'd1;
        end
      end
      STOP: begin
        if (baud == '0) state_next = IDLE;
        else            baud_next  = baud - 16'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud      <= '0;
      shift     <= '0;
      idx       <= '0;
      tx        <= 1'b1;
      irq_empty <= 1'b1;
    end else begin
      state     <= state_next;
      baud      <= baud_next;
      shift     <= shift_next;
      idx       <= idx_next;
      tx        <= tx_next;
      irq_empty <= fifo_empty && (state == IDLE);
    end
  end

endmodule

// File: tb/tb_snowflake_uart_tx.sv
// Bench for snowflake_uart_tx: frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_snowflake_uart_tx;
  import snowflake_uart_pkg::*;

  localparam int DEPTH = 8;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      tx, irq_empty;
  tx_state_e state_dbg;

  snowflake_uart_tx_if bus();

  snowflake_uart_tx #(.DEPTH(DEPTH), .DEFAULT_DIV(16'd207)) dut (
    .clk       (clk),
    .rst       (rst),
    .sys       (bus),
    .tx        (tx),
    .irq_empty (irq_empty),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  logic [7:0]  m_q[$];
  logic        m_active;
  logic [9:0]  m_bits;
  int          m_bit, m_left, m_sz;
  logic [15:0] m_div;
  logic        m_ovf, m_line;
  logic [7:0]  m_b;
  logic [5:0]  m_off;
  logic        exp_tx, exp_irq;
  logic [31:0] exp_rd;

  function automatic logic [31:0] model_read(input logic [5:0] off, input int sz);
    if (off == 6'h01)
      return {17'b0, 7'(sz), 4'b0, m_ovf, sz == 0, sz == DEPTH, m_active || (sz > 0)};
    else if (off == 6'h02)
      return {16'h0000, m_div};
    return 32'h0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_active = 1'b0;
      m_bit    = 0;
      m_left   = 0;
      m_div    = 16'd207;
      m_ovf    = 1'b0;
      exp_tx   = 1'b1;
      exp_irq  = 1'b1;
      exp_rd   = 32'h0;
    end else begin
      m_sz   = m_q.size();
      m_off  = bus.sys_addr[7:2];
      m_line = m_active ? m_bits[m_bit] : 1'b1;
      if (bus.sys_en && !bus.sys_wr_en) exp_rd = model_read(m_off, m_sz);
      exp_tx  = m_line;
      exp_irq = (m_sz == 0) && !m_active;
      // each bit lasts (divider at its start)+1 cycles; one idle cycle between frames
      if (m_active) begin
        m_left--;
        if (m_left == 0) begin
          m_bit++;
          if (m_bit == 10) m_active = 1'b0;
          else             m_left = int'(m_div) + 1;
        end
      end else if (m_sz > 0) begin
        m_b      = m_q.pop_front();
        m_bits   = {1'b1, m_b, 1'b0};
        m_bit    = 0;
        m_left   = int'(m_div) + 1;
        m_active = 1'b1;
      end
      if (bus.sys_en && bus.sys_wr_en) begin
        case (m_off)
          6'h00: if (m_sz == DEPTH) m_ovf = 1'b1; else m_q.push_back(bus.sys_wr_data[7:0]);
          6'h01: if (bus.sys_wr_data[3]) m_ovf = 1'b0;
          6'h02: m_div = bus.sys_wr_data[15:0];
          default: ;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic log_en = 1'b0;
  logic tx_log[$];

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      check("model_tx", tx, exp_tx);
      check("model_irq_empty", irq_empty, exp_irq);
      check("model_rd_data", bus.sys_rd_data, exp_rd);
      if (log_en) tx_log.push_back(tx);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [5:0] off, input logic [31:0] data);
    bus.sys_en      = 1'b1;
    bus.sys_wr_en   = 1'b1;
    bus.sys_addr    = {24'h0, off, 2'b00};
    bus.sys_wr_data = data;
    @(posedge clk);
    #1;
    bus.sys_en = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] off);
    bus.sys_en    = 1'b1;
    bus.sys_wr_en = 1'b0;
    bus.sys_addr  = {24'h0, off, 2'b00};
    @(posedge clk);
    #1;
    bus.sys_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  logic [9:0] a5_frame;
  int         runs[$];
  int         run_len, falls, lows;
  logic       prev;
  int         exp_runs[9] = '{4, 4, 4, 4, 8, 8, 8, 8, 8};

  initial begin
    bus.sys_en      = 1'b0;
    bus.sys_wr_en   = 1'b0;
    bus.sys_addr    = '0;
    bus.sys_wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check("reset_tx", tx, 1);
    check("reset_irq_empty", irq_empty, 1);
    check("reset_rd_data", bus.sys_rd_data, 0);
    bus_read(REG_STATUS);
    check("reset_status", bus.sys_rd_data, 32'h0000_0004);
    bus_read(REG_CLKDIV);
    check("reset_clkdiv", bus.sys_rd_data, 32'd207);
    bus_read(REG_TXDATA);
    check("read_txdata_zero", bus.sys_rd_data, 0);
    bus_write(6'h05, 32'hFFFF_FFFF);
    bus_read(6'h05);
    check("read_unmapped_zero", bus.sys_rd_data, 0);

    // single 0xA5 frame with CLKDIV=3
    bus_write(REG_CLKDIV, 32'd3);
    a5_frame = 10'b1101001010;
    bus_write(REG_TXDATA, 32'hA5);
    check("a5_tx_after_write", tx, 1);
    idle(1);
    check("a5_tx_idle_cycle", tx, 1);
    idle(1);
    check("a5_tx_fall_2_edges", tx, 0);
    for (int k = 0; k < 10; k++) begin
      idle(k == 0 ? 1 : 4);
      check($sformatf("a5_bit%0d", k), tx, a5_frame[k]);
    end
    idle(2);
    check("a5_irq_during_stop", irq_empty, 0);
    idle(1);
    check("a5_irq_after_stop", irq_empty, 1);

    // nine bytes back to back at CLKDIV=0
    bus_write(REG_CLKDIV, 32'd0);
    tx_log.delete();
    log_en = 1'b1;
    for (int i = 0; i < 9; i++) bus_write(REG_TXDATA, 32'hFF);
    idle(120);
    log_en = 1'b0;
    falls = 0;
    lows  = 0;
    prev  = 1'b1;
    foreach (tx_log[i]) begin
      if (prev && !tx_log[i]) falls++;
      if (!tx_log[i]) lows++;
      prev = tx_log[i];
    end
    check("b2b_frame_count", falls, 9);
    check("b2b_start_cycles", lows, 9);
    bus_read(REG_STATUS);
    check("b2b_status_no_overflow", bus.sys_rd_data, 32'h0000_0004);

    // overflow at CLKDIV=100
    bus_write(REG_CLKDIV, 32'd100);
    for (int i = 0; i < 10; i++) bus_write(REG_TXDATA, 32'h10 + i);
    bus_read(REG_STATUS);
    check("ovf_status_full", bus.sys_rd_data, 32'h0000_080B);
    bus_write(REG_STATUS, 32'h0000_0008);
    bus_read(REG_STATUS);
    check("ovf_status_cleared", bus.sys_rd_data, 32'h0000_0803);
    bus_write(REG_CLKDIV, 32'd0);
    idle(200);
    bus_read(REG_STATUS);
    check("ovf_drained_status", bus.sys_rd_data, 32'h0000_0004);

    // CLKDIV 3 -> 7 during data bit 2 of 0x55
    bus_write(REG_CLKDIV, 32'd3);
    tx_log.delete();
    log_en = 1'b1;
    bus_write(REG_TXDATA, 32'h55);
    idle(13);
    bus_write(REG_CLKDIV, 32'd7);
    idle(100);
    log_en = 1'b0;
    runs.delete();
    run_len = 1;
    for (int i = 1; i < tx_log.size(); i++) begin
      if (tx_log[i] == tx_log[i-1]) run_len++;
      else begin
        runs.push_back(run_len);
        run_len = 1;
      end
    end
    runs.push_back(run_len);
    check("mid_runs_count_ok", runs.size() >= 10, 1);
    for (int i = 0; i < 9; i++)
      check($sformatf("mid_run%0d", i), (runs.size() > i + 1) ? runs[i+1] : -1, exp_runs[i]);

    // reset during data bit 4 with three bytes queued
    bus_write(REG_CLKDIV, 32'd3);
    for (int i = 0; i < 4; i++) bus_write(REG_TXDATA, 32'h00);
    idle(19);
    #2;
    check("pre_reset_tx_low", tx, 0);
    rst = 1'b1;
    #1;
    check("async_reset_tx", tx, 1);
    check("async_reset_irq", irq_empty, 1);
    #2;
    idle(2);
    rst = 1'b0;
    idle(1);
    bus_read(REG_STATUS);
    check("post_reset_status", bus.sys_rd_data, 32'h0000_0004);
    bus_read(REG_CLKDIV);
    check("post_reset_clkdiv", bus.sys_rd_data, 32'd207);
    idle(60);
    check("post_reset_tx_idle", tx, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
